// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller slice.
//   - funct3 codes for conditional branches
//   - io_pc_sel encodings (sequential / ALU target / fall-through)
//   - FSM state encodings and BHT reset value
//   - EX-stage request struct plus decode and saturating-update helpers
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;
  localparam logic [1:0] PC_SEL_FALL = 2'd2;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  // Weakly not-taken.
  localparam logic [1:0] BHT_RST = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic        pred_taken;
  } ex_req_t;

  // funct3 010/011 are not branches; they fall to the default and read as
  // not taken.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                    input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic br_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && c != 2'b11)       n = c + 2'd1;
    else if (!taken && c != 2'b00) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bht_table.sv
// 2-bit saturating-counter branch history table.
//   clock, reset       : clock, async active-low reset (all entries -> 01)
//   rd_idx / rd_cnt    : combinational read port (no write bypass)
//   wr_en/wr_idx/wr_taken : synchronous saturating update
module bht_table
  import branch_ctrl_pkg::*;
#(
  parameter int  BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] tbl [BHT_ENTRIES];

  // Read sees the pre-update value when rd_idx == wr_idx in the same cycle.
  assign rd_cnt = tbl[rd_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) tbl[i] <= BHT_RST;
    end else if (wr_en) begin
      tbl[wr_idx] <= sat_upd(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch controller for the rv151 pipeline.
//   Drives io_BrUn to branch_comp, resolves taken/not-taken, compares with the
//   IF-stage prediction, and on a mispredict issues io_pc_sel/io_flush in the
//   same cycle, then masks EX for RECOVER_CYCLES cycles. Owns the BHT used for
//   IF-stage prediction and two wrapping perf counters.
// Ports:
//   clock, reset (async, active-low)
//   io_if_pc -> io_if_pred_taken          : IF prediction lookup
//   io_ex_*, io_stall, io_BrEq, io_BrLt   : EX instruction and compare results
//   io_BrUn, io_pc_sel, io_fallthrough_pc, io_flush, io_illegal : EX controls
//   io_cnt_branch, io_cnt_mispred         : perf counters
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES    = 64,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_if_pc,
  output logic        io_if_pred_taken,
  input  logic        io_ex_valid,
  input  logic        io_ex_is_branch,
  input  logic        io_ex_is_jal,
  input  logic        io_ex_is_jalr,
  input  logic [2:0]  io_ex_funct3,
  input  logic [31:0] io_ex_pc,
  input  logic        io_ex_pred_taken,
  input  logic        io_stall,
  input  logic        io_BrEq,
  input  logic        io_BrLt,
  output logic        io_BrUn,
  output logic [1:0]  io_pc_sel,
  output logic [31:0] io_fallthrough_pc,
  output logic        io_flush,
  output logic        io_illegal,
  output logic [31:0] io_cnt_branch,
  output logic [31:0] io_cnt_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int RC_W  = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

  ex_req_t ex;
  assign ex = '{valid:      io_ex_valid,
                is_branch:  io_ex_is_branch,
                is_jal:     io_ex_is_jal,
                is_jalr:    io_ex_is_jalr,
                funct3:     io_ex_funct3,
                pc:         io_ex_pc,
                pred_taken: io_ex_pred_taken};

  logic [0:0]    state;
  logic [RC_W-1:0] rc_cnt;
  logic          resolve;
  logic          br_tk;
  logic          act_taken;
  logic          mispred;
  logic [1:0]    bht_rd;

  // ---------------- BHT ----------------
  bht_table #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (io_if_pc[IDX_W+1:2]),
    .rd_cnt   (bht_rd),
    .wr_en    (resolve & ex.is_branch),
    .wr_idx   (ex.pc[IDX_W+1:2]),
    .wr_taken (br_tk)
  );

  assign io_if_pred_taken = bht_rd[1];

  // Only the index bits of the IF PC and the MSB of the counter matter.
  logic unused_bits;
  assign unused_bits = ^{io_if_pc[31:IDX_W+2], io_if_pc[1:0], bht_rd[0]};

  // ---------------- resolve / mispredict ----------------
  // bltu/bgeu (and the illegal 010/011) have funct3[1] set.
  assign io_BrUn           = ex.funct3[1];
  assign io_fallthrough_pc = ex.pc + 32'd4;

  assign resolve   = (state == ST_IDLE) & ex.valid & ~io_stall;
  assign br_tk     = br_taken(ex.funct3, io_BrEq, io_BrLt);
  assign act_taken = ex.is_jal | ex.is_jalr | (ex.is_branch & br_tk);

  // JALR always redirects: IF has no way to know its target.
  assign mispred = resolve & ((ex.is_branch & (br_tk != ex.pred_taken)) |
                              (ex.is_jal & ~ex.pred_taken) |
                              ex.is_jalr);

  always_comb begin
    io_pc_sel  = PC_SEL_SEQ;
    io_flush   = 1'b0;
    io_illegal = resolve & ex.is_branch & br_illegal(ex.funct3);
    if (mispred) begin
      io_flush  = 1'b1;
      io_pc_sel = act_taken ? PC_SEL_ALU : PC_SEL_FALL;
    end
  end

  // ---------------- FSM + recovery down-counter ----------------
  // Stall is deliberately not looked at in RECOVER: the redirect already
  // happened, the window only hides the wrong-path instruction(s).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rc_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mispred) begin
          state  <= ST_RECOVER;
          rc_cnt <= RC_W'(RECOVER_CYCLES - 1);
        end
        ST_RECOVER: begin
          if (rc_cnt == '0) state <= ST_IDLE;
          else              rc_cnt <= rc_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- perf counters (wrap naturally) ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_cnt_branch  <= '0;
      io_cnt_mispred <= '0;
    end else begin
      if (resolve & ex.is_branch) io_cnt_branch  <= io_cnt_branch + 32'd1;
      if (mispred)                io_cnt_mispred <= io_cnt_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: hand-computed expectations, one check task.
module tb_branch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] io_if_pc = '0;
  logic        io_if_pred_taken;
  logic        io_ex_valid = 0, io_ex_is_branch = 0, io_ex_is_jal = 0, io_ex_is_jalr = 0;
  logic [2:0]  io_ex_funct3 = '0;
  logic [31:0] io_ex_pc = '0;
  logic        io_ex_pred_taken = 0, io_stall = 0, io_BrEq = 0, io_BrLt = 0;
  logic        io_BrUn;
  logic [1:0]  io_pc_sel;
  logic [31:0] io_fallthrough_pc;
  logic        io_flush, io_illegal;
  logic [31:0] io_cnt_branch, io_cnt_mispred;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  branch_ctrl #(.BHT_ENTRIES(64), .RECOVER_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .io_if_pc(io_if_pc), .io_if_pred_taken(io_if_pred_taken),
    .io_ex_valid(io_ex_valid), .io_ex_is_branch(io_ex_is_branch),
    .io_ex_is_jal(io_ex_is_jal), .io_ex_is_jalr(io_ex_is_jalr),
    .io_ex_funct3(io_ex_funct3), .io_ex_pc(io_ex_pc),
    .io_ex_pred_taken(io_ex_pred_taken), .io_stall(io_stall),
    .io_BrEq(io_BrEq), .io_BrLt(io_BrLt), .io_BrUn(io_BrUn),
    .io_pc_sel(io_pc_sel), .io_fallthrough_pc(io_fallthrough_pc),
    .io_flush(io_flush), .io_illegal(io_illegal),
    .io_cnt_branch(io_cnt_branch), .io_cnt_mispred(io_cnt_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // kind: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic drive(input logic v, input int kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic pred, input logic eq,
                       input logic lt, input logic st);
    io_ex_valid      = v;
    io_ex_is_branch  = (kind == 1);
    io_ex_is_jal     = (kind == 2);
    io_ex_is_jalr    = (kind == 3);
    io_ex_funct3     = f3;
    io_ex_pc         = pc;
    io_ex_pred_taken = pred;
    io_BrEq          = eq;
    io_BrLt          = lt;
    io_stall         = st;
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    io_if_pc = pc;
    #1;
    chk(tag, {31'b0, io_if_pred_taken}, {31'b0, exp});
  endtask

  initial begin
    // ---- reset state ----
    #2;
    chk("rst_pc_sel",  {30'b0, io_pc_sel}, 32'd0);
    chk("rst_flush",   {31'b0, io_flush}, 32'd0);
    chk("rst_illegal", {31'b0, io_illegal}, 32'd0);
    chk("rst_cnt_br",  io_cnt_branch, 32'd0);
    chk("rst_cnt_mp",  io_cnt_mispred, 32'd0);
    pred_at("rst_pred", 32'h100, 1'b0);
    #7 reset = 1'b1;                       // t=10, away from edges

    // ---- BEQ taken, predicted not-taken -> redirect to ALU target ----
    tick();
    drive(1, 1, 3'b000, 32'h100, 0, 1, 0, 0);
    chk("beq_pc_sel", {30'b0, io_pc_sel}, 32'd1);
    chk("beq_flush",  {31'b0, io_flush}, 32'd1);
    chk("beq_brun",   {31'b0, io_BrUn}, 32'd0);
    tick();
    idle();
    chk("beq_state",  {31'b0, dut.state}, 32'd1);
    chk("beq_mp",     io_cnt_mispred, 32'd1);
    chk("beq_br",     io_cnt_branch, 32'd1);
    pred_at("beq_bht", 32'h100, 1'b1);     // 01 -> 10
    tick();
    chk("beq_idle",   {31'b0, dut.state}, 32'd0);

    // ---- BLTU not taken, pred 0: no flush, BHT[1] 01 -> 00 -> 00 ----
    drive(1, 1, 3'b110, 32'h204, 0, 0, 0, 0);
    chk("bltu_brun",  {31'b0, io_BrUn}, 32'd1);
    chk("bltu_flush", {31'b0, io_flush}, 32'd0);
    chk("bltu_psel",  {30'b0, io_pc_sel}, 32'd0);
    tick();
    chk("bltu_flush2", {31'b0, io_flush}, 32'd0);
    tick();
    chk("bltu_br",    io_cnt_branch, 32'd3);
    // taken now: 00 -> 01 still predicts not-taken (01 would have gone to 10)
    drive(1, 1, 3'b110, 32'h204, 0, 0, 1, 0);
    chk("bltu_tk_psel", {30'b0, io_pc_sel}, 32'd1);
    tick();
    idle();
    pred_at("bltu_sat0", 32'h204, 1'b0);
    chk("bltu_mp",    io_cnt_mispred, 32'd2);
    tick();

    // ---- BNE at top of address space ----
    drive(1, 1, 3'b001, 32'hFFFF_FFFC, 1, 0, 0, 0);
    chk("bne_flush",  {31'b0, io_flush}, 32'd0);
    chk("bne_ft",     io_fallthrough_pc, 32'h0);
    tick();
    pred_at("bne_bht", 32'hFFFF_FFFC, 1'b1);   // 01 -> 10
    // mispredicted not-taken; same-index read shows old value
    drive(1, 1, 3'b001, 32'hFFFF_FFFC, 1, 1, 0, 0);
    chk("bne_nt_psel", {30'b0, io_pc_sel}, 32'd2);
    chk("bne_nt_flush", {31'b0, io_flush}, 32'd1);
    chk("bne_nt_ft",   io_fallthrough_pc, 32'h0);
    chk("bne_nobypass", {31'b0, io_if_pred_taken}, 32'd1);
    tick();
    idle();
    pred_at("bne_after", 32'hFFFF_FFFC, 1'b0); // 10 -> 01
    chk("bne_br",     io_cnt_branch, 32'd6);
    chk("bne_mp",     io_cnt_mispred, 32'd3);
    tick();

    // ---- JALR always redirects; branch during RECOVER is ignored ----
    drive(1, 3, 3'b000, 32'h300, 1, 0, 0, 0);
    chk("jalr_flush", {31'b0, io_flush}, 32'd1);
    chk("jalr_psel",  {30'b0, io_pc_sel}, 32'd1);
    tick();
    drive(1, 1, 3'b000, 32'h100, 1, 0, 0, 0);  // would mispredict if seen
    chk("rec_flush",  {31'b0, io_flush}, 32'd0);
    chk("rec_psel",   {30'b0, io_pc_sel}, 32'd0);
    tick();
    idle();
    chk("rec_br",     io_cnt_branch, 32'd6);
    chk("rec_mp",     io_cnt_mispred, 32'd4);
    pred_at("rec_bht", 32'h100, 1'b1);         // still 10

    // ---- JAL predicted taken: no redirect ----
    drive(1, 2, 3'b000, 32'h400, 1, 0, 0, 0);
    chk("jal_flush",  {31'b0, io_flush}, 32'd0);
    tick();
    idle();
    chk("jal_mp",     io_cnt_mispred, 32'd4);
    chk("jal_br",     io_cnt_branch, 32'd6);

    // ---- illegal funct3 010: not taken, still updates BHT ----
    drive(1, 1, 3'b010, 32'h100, 0, 1, 1, 0);
    chk("ill_flag",   {31'b0, io_illegal}, 32'd1);
    chk("ill_flush",  {31'b0, io_flush}, 32'd0);
    tick();
    idle();
    chk("ill_flag0",  {31'b0, io_illegal}, 32'd0);
    pred_at("ill_bht", 32'h100, 1'b0);         // 10 -> 01
    chk("ill_br",     io_cnt_branch, 32'd7);

    // ---- stall holds a mispredicting BGE ----
    drive(1, 1, 3'b101, 32'h208, 0, 0, 0, 1);
    chk("stl_flush",  {31'b0, io_flush}, 32'd0);
    chk("stl_psel",   {30'b0, io_pc_sel}, 32'd0);
    tick();
    chk("stl_br",     io_cnt_branch, 32'd7);
    drive(1, 1, 3'b101, 32'h208, 0, 0, 0, 0);
    chk("rel_flush",  {31'b0, io_flush}, 32'd1);
    chk("rel_psel",   {30'b0, io_pc_sel}, 32'd1);
    tick();
    idle();
    chk("rel_br",     io_cnt_branch, 32'd8);
    chk("rel_mp",     io_cnt_mispred, 32'd5);
    chk("rel_state",  {31'b0, dut.state}, 32'd1);
    pred_at("rel_bht", 32'h208, 1'b1);         // 01 -> 10

    // ---- reset mid-RECOVER ----
    reset = 1'b0;
    #1;
    chk("mrst_state", {31'b0, dut.state}, 32'd0);
    chk("mrst_br",    io_cnt_branch, 32'd0);
    chk("mrst_mp",    io_cnt_mispred, 32'd0);
    for (int i = 0; i < 64; i++) begin
      io_if_pc = 32'(i) << 2;
      #0.1;
      if (io_if_pred_taken !== 1'b0) chk("mrst_bht", {31'b0, io_if_pred_taken}, 32'd0);
    end
    pred_at("mrst_208", 32'h208, 1'b0);
    pred_at("mrst_100", 32'h100, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // ---- no type flag set: resolves with no effect ----
    tick();
    drive(1, 0, 3'b000, 32'h500, 0, 1, 0, 0);
    chk("none_flush", {31'b0, io_flush}, 32'd0);
    tick();
    chk("none_br",    io_cnt_branch, 32'd0);
    chk("none_mp",    io_cnt_mispred, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
